// File: rtl/gray_pkg.sv
// Shared definitions for Gray-code consumers: tracker state encoding and a
// width-agnostic Gray-to-binary decoder.
package gray_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

  localparam int GRAY_MAX_W = 32;

  // Leading zeros decode to zeros, so a narrower word can be zero-extended,
  // decoded here and truncated back to its own width.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded bus; every stage resets to zero.
module gray_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray-coded count crossing: synchronise, decode, and accept
// only +/-1 steps; anything else latches an error until err_clr.
module gray_ptr_rx
  import gray_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  output logic             chg,
  output logic             dir,
  output logic             step_err,
  output logic [1:0]       dbg_state
);

  // Handshake: no ready; b_out may be consumed whenever b_valid is high, and
  // chg marks the single cycle in which b_out took a new legal value.
  localparam int CW = $clog2(SYNC_STAGES + 1);

  state_e                state, state_nx;
  logic [CW-1:0]         fill_cnt, cnt_nx;
  logic [WIDTH-1:0]      g_s, b_dec, diff, b_nx;
  logic [GRAY_MAX_W-1:0] g_ext, dec_full;
  logic                  valid_nx, chg_nx, dir_nx, err_nx;

  gray_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (g_in),
    .q     (g_s)
  );

  assign g_ext     = GRAY_MAX_W'(g_s);
  assign dec_full  = gray2bin(g_ext);
  assign b_dec     = dec_full[WIDTH-1:0];
  assign diff      = b_dec - b_out;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    cnt_nx   = fill_cnt;
    b_nx     = b_out;
    valid_nx = b_valid;
    chg_nx   = 1'b0;
    dir_nx   = dir;
    err_nx   = step_err;
    unique case (state)
      FILL: begin
        valid_nx = 1'b0;
        // The chain only holds real samples once SYNC_STAGES edges have passed.
        if (fill_cnt == CW'(SYNC_STAGES)) begin
          b_nx     = b_dec;
          valid_nx = 1'b1;
          err_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = TRACK;
        end else begin
          cnt_nx = fill_cnt + CW'(1);
        end
      end
      TRACK: begin
        if (diff == '0) begin
          b_nx = b_out;
        end else if (diff == WIDTH'(1)) begin
          b_nx   = b_dec;
          chg_nx = 1'b1;
          dir_nx = 1'b1;
        end else if (diff == '1) begin
          b_nx   = b_dec;
          chg_nx = 1'b1;
          dir_nx = 1'b0;
        end else begin
          err_nx   = 1'b1;
          valid_nx = 1'b0;
          state_nx = ERROR;
        end
      end
      ERROR: begin
        if (err_clr) begin
          cnt_nx   = '0;
          state_nx = FILL;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= '0;
      b_out    <= '0;
      b_valid  <= 1'b0;
      chg      <= 1'b0;
      dir      <= 1'b0;
      step_err <= 1'b0;
    end else begin
      state    <= state_nx;
      fill_cnt <= cnt_nx;
      b_out    <= b_nx;
      b_valid  <= valid_nx;
      chg      <= chg_nx;
      dir      <= dir_nx;
      step_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Bench for gray_ptr_rx: directed Gray sequences, expected events queued at
// stimulus time and popped by a monitor when the DUT reports them.
module tb_gray_ptr_rx;
  import gray_pkg::*;

  localparam int W = 3;
  localparam logic [1:0] K_CHG  = 2'd0;
  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] g_in;
  logic         err_clr;
  logic [W-1:0] b_out;
  logic         b_valid, chg, dir, step_err;
  logic [1:0]   dbg_state;

  // expected event word: {kind, dir, b_out}
  logic [W+2:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  gray_ptr_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .g_in      (g_in),
    .err_clr   (err_clr),
    .b_out     (b_out),
    .b_valid   (b_valid),
    .chg       (chg),
    .dir       (dir),
    .step_err  (step_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic handle(input logic [1:0] kind);
    logic [W+2:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d b_out %0d with nothing expected at %0t",
               kind, b_out, $time);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", 32'(kind), 32'(e[W+2:W+1]));
      check("ev_b_out", 32'(b_out), 32'(e[W-1:0]));
      if (kind == K_CHG)  check("ev_dir", 32'(dir), 32'(e[W]));
      if (kind == K_ERR)  check("ev_err_valid", 32'(b_valid), 32'd0);
      if (kind == K_LOAD) check("ev_load_err", 32'(step_err), 32'd0);
    end
  endtask

  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (chg) handle(K_CHG);
      if (b_valid && !prev_valid) handle(K_LOAD);
      if (step_err && !prev_err) handle(K_ERR);
    end
    prev_valid = b_valid;
    prev_err   = step_err;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic step(input logic [W-1:0] g, input logic [W-1:0] b, input logic d);
    g_in = g;
    exp_q.push_back({K_CHG, d, b});
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
    finish_run();
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] walk_g [6];
    walk_g = '{3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    rst_n   = 1'b0;
    g_in    = '0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_b_out", 32'(b_out), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_chg", 32'(chg), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_step_err", 32'(step_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(FILL));

    // release: valid after the 3rd edge
    exp_q.push_back({K_LOAD, 1'b0, 3'd0});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("fill_wait_valid", 32'(b_valid), 32'd0);
    @(negedge clk);
    check("fill_done_valid", 32'(b_valid), 32'd1);
    check("fill_done_b_out", 32'(b_out), 32'd0);
    repeat (2) @(negedge clk);

    // first step with explicit latency check
    g_in = 3'b001;
    exp_q.push_back({K_CHG, 1'b1, 3'd1});
    repeat (2) @(negedge clk);
    check("lat_early_chg", 32'(chg), 32'd0);
    @(negedge clk);
    check("lat_edge_chg", 32'(chg), 32'd1);
    check("lat_edge_b_out", 32'(b_out), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) step(walk_g[i], W'(i + 2), 1'b1);

    // wrap both ways
    step(3'b000, 3'd0, 1'b1);
    step(3'b100, 3'd7, 1'b0);
    step(3'b000, 3'd0, 1'b1);
    check("wrap_step_err", 32'(step_err), 32'd0);

    // illegal jump 0 -> 2 (Gray 000 -> 011)
    g_in = 3'b011;
    exp_q.push_back({K_ERR, 1'b0, 3'd0});
    repeat (4) @(negedge clk);
    check("err_state", 32'(dbg_state), 32'(ERROR));
    g_in = 3'b110;
    repeat (4) @(negedge clk);
    g_in = 3'b011;
    repeat (4) @(negedge clk);
    check("err_hold_b_out", 32'(b_out), 32'd0);
    check("err_hold_valid", 32'(b_valid), 32'd0);
    check("err_hold_sticky", 32'(step_err), 32'd1);

    // recover with g_in = 011 -> b_out = 2
    exp_q.push_back({K_LOAD, 1'b0, 3'd2});
    pulse_clr();
    check("clr_state_fill", 32'(dbg_state), 32'(FILL));
    repeat (2) @(negedge clk);
    check("clr_wait_valid", 32'(b_valid), 32'd0);
    @(negedge clk);
    check("clr_done_valid", 32'(b_valid), 32'd1);
    check("clr_done_b_out", 32'(b_out), 32'd2);
    check("clr_done_err", 32'(step_err), 32'd0);
    repeat (2) @(negedge clk);

    // walk down to 0
    step(3'b001, 3'd1, 1'b0);
    step(3'b000, 3'd0, 1'b0);

    // err_clr while tracking must do nothing
    pulse_clr();
    repeat (3) @(negedge clk);
    check("track_clr_state", 32'(dbg_state), 32'(TRACK));
    check("track_clr_valid", 32'(b_valid), 32'd1);

    // single-bit flip 000 -> 010 decodes 0 -> 3
    g_in = 3'b010;
    exp_q.push_back({K_ERR, 1'b0, 3'd0});
    repeat (4) @(negedge clk);
    check("flip_step_err", 32'(step_err), 32'd1);

    // recover at b_out = 5 (Gray 111)
    g_in = 3'b111;
    repeat (4) @(negedge clk);
    exp_q.push_back({K_LOAD, 1'b0, 3'd5});
    pulse_clr();
    repeat (5) @(negedge clk);
    check("recover5_b_out", 32'(b_out), 32'd5);
    check("recover5_dir", 32'(dir), 32'd0);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_b_out", 32'(b_out), 32'd0);
    check("arst_b_valid", 32'(b_valid), 32'd0);
    check("arst_chg", 32'(chg), 32'd0);
    check("arst_dir", 32'(dir), 32'd0);
    check("arst_step_err", 32'(step_err), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(FILL));
    @(negedge clk);
    exp_q.push_back({K_LOAD, 1'b0, 3'd5});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("refill_wait_valid", 32'(b_valid), 32'd0);
    @(negedge clk);
    check("refill_done_valid", 32'(b_valid), 32'd1);
    check("refill_done_b_out", 32'(b_out), 32'd5);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    finish_run();
  end

endmodule
